// File: rtl/victim_writeback_buffer.sv
// Single-entry victim write-back buffer.
// Takes one dirty line from the cache in a single cycle. It drains the line
// to memory as an address phase, then a word-serial data burst, then a write
// response. While it holds the line it flags lookups that hit that line.
module victim_writeback_buffer #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  // cache side
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [32*LINE_WORDS-1:0] in_data,
  // memory write-address channel
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [ADDR_WIDTH-1:0]   aw_addr,
  // memory write-data channel
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [31:0]             w_data,
  output logic [3:0]              w_strb,
  output logic                    w_last,
  // memory write-response channel
  input  logic                    b_valid,
  output logic                    b_ready,
  // lookup snoop
  input  logic [ADDR_WIDTH-1:0]   lookup_addr,
  output logic                    lookup_conflict,
  output logic                    busy
);

  localparam int BW = $clog2(LINE_WORDS);
  // Byte-offset bits within a line; cleared on the latched address.
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WORDS*4-1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]              r_state;
  logic [BW-1:0]           r_beat;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [32*LINE_WORDS-1:0] r_data;

  logic                    w_is_last;
  logic [31:0]             w_word;

  assign w_is_last = (r_beat == LAST_BEAT);
  assign w_word    = r_data[32*int'(r_beat) +: 32];

  // Handshake FSM: latch line in IDLE, then address, beats, response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_addr  <= in_addr & ~OFF_MASK;
            r_data  <= in_data;
            r_beat  <= '0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (aw_ready) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_ready) begin
            // power-of-two line length, so the counter wraps naturally
            r_beat <= r_beat + 1'b1;
            if (w_is_last) r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // response code is deliberately not examined
          if (b_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Channel outputs decoded straight from the state register.
  always_comb begin
    in_ready = (r_state == S_IDLE);
    busy     = (r_state != S_IDLE);
    aw_valid = (r_state == S_ADDR);
    aw_addr  = r_addr;
    w_valid  = (r_state == S_DATA);
    w_data   = w_valid ? w_word : 32'h0;
    w_strb   = w_valid ? 4'hf : 4'h0;
    w_last   = w_valid && w_is_last;
    b_ready  = (r_state == S_RESP);
  end

  // Snoop compare on line address only; the offset bits are masked out.
  always_comb begin
    lookup_conflict = busy && ((lookup_addr & ~OFF_MASK) == r_addr);
  end

endmodule
